// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper
// Conditions hps_io joystick words into the per-player control buses that
// the game core expects. It handles merged or independent routing, SOCD
// cleaning, coin pulse shaping to a fixed number of frames, per-player
// autofire on button 0, and a lockout while a ROM download is in progress.
//
// Coin FSM (one per player):
//   state      | meaning
//   C_IDLE     | armed, waiting for a coin rising edge
//   C_PULSE    | coin output high, counting frame ticks down
//   C_WAIT_REL | pulse finished or aborted, waiting for coin release
//
// Output bus per player, LSB first: up, down, left, right,
// buttons[NBUTTONS-1:0], start, coin.

module arcade_input_mapper #(
  parameter int NPLAYERS    = 2,
  parameter int NBUTTONS    = 1,
  parameter int COIN_FRAMES = 3,
  parameter int AF_FRAMES   = 2,
  parameter int SOCD        = 1
) (
  input  logic                             clk_sys,
  input  logic                             reset,
  input  logic                             vblank,
  input  logic                             lock,
  input  logic                             merged,
  input  logic [NPLAYERS-1:0]              autofire_en,
  input  logic [NPLAYERS*16-1:0]           joystick,
  output logic [NPLAYERS*(NBUTTONS+6)-1:0] player_out
);

  localparam int W = NBUTTONS + 6;
  localparam int S = 4 + NBUTTONS;
  localparam logic [3:0] COIN_LOAD = 4'(COIN_FRAMES);
  localparam logic [3:0] AF_LOAD   = 4'(AF_FRAMES);

  typedef enum logic [1:0] {
    C_IDLE     = 2'd0,
    C_PULSE    = 2'd1,
    C_WAIT_REL = 2'd2
  } coin_state_t;

  logic        vblank_q;
  logic        tick;
  logic [15:0] joy_or;

  // Delayed vblank; its rising edge marks the start of a frame.
  always_ff @(posedge clk_sys) begin
    if (reset) vblank_q <= 1'b0;
    else       vblank_q <= vblank;
  end

  assign tick = vblank & ~vblank_q;

  // OR of every pad, used as the common source in merged mode.
  always_comb begin
    joy_or = '0;
    for (int i = 0; i < NPLAYERS; i++) begin
      joy_or = joy_or | joystick[16*i +: 16];
    end
  end

  for (genvar p = 0; p < NPLAYERS; p++) begin : g_player
    logic [15:0]         word;
    logic [15:0]         src;
    logic                start_in;
    logic                coin_in;
    logic                up_o, down_o, left_o, right_o;
    logic [NBUTTONS-1:0] btn_raw;
    logic [NBUTTONS-1:0] btn_o;
    logic                coin_q;
    coin_state_t         state, state_nx;
    logic [3:0]          cnt, cnt_nx;
    logic                af_active;
    logic                af_phase;
    logic [3:0]          af_cnt;
    logic [W-1:0]        out_nx;
    logic [W-1:0]        out_q;
    logic                unused_src;

    assign word    = joystick[16*p +: 16];
    assign src     = merged ? joy_or : word;
    assign coin_in = src[S+2];
    assign btn_raw = src[4 +: NBUTTONS];

    // Select and reserved bits above coin never reach the outputs through src.
    assign unused_src = ^{src[15:S+3], src[S+1]};

    // Start routing: merged mode maps start to player 0 and select to player 1.
    always_comb begin
      start_in = 1'b0;
      if (merged) begin
        if (p == 0)      start_in = joy_or[S];
        else if (p == 1) start_in = joy_or[S+1];
        else             start_in = 1'b0;
      end else begin
        start_in = word[S];
      end
    end

    // Direction cleaning: opposing directions cancel when SOCD is enabled.
    always_comb begin
      right_o = src[0];
      left_o  = src[1];
      down_o  = src[2];
      up_o    = src[3];
      if (SOCD != 0) begin
        if (src[0] && src[1]) begin
          right_o = 1'b0;
          left_o  = 1'b0;
        end
        if (src[2] && src[3]) begin
          down_o = 1'b0;
          up_o   = 1'b0;
        end
      end
    end

    // Coin FSM state, frame counter and coin edge register.
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        state  <= C_IDLE;
        cnt    <= '0;
        coin_q <= 1'b0;
      end else begin
        state  <= state_nx;
        cnt    <= cnt_nx;
        coin_q <= coin_in;
      end
    end

    // Coin FSM next state; a tick on the load cycle is ignored because IDLE never counts.
    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (lock) begin
        state_nx = C_WAIT_REL;
        cnt_nx   = '0;
      end else begin
        case (state)
          C_IDLE: begin
            if (coin_in && !coin_q) begin
              state_nx = C_PULSE;
              cnt_nx   = COIN_LOAD;
            end
          end
          C_PULSE: begin
            if (tick) begin
              if (cnt <= 4'd1) begin
                state_nx = C_WAIT_REL;
                cnt_nx   = '0;
              end else begin
                cnt_nx = cnt - 4'd1;
              end
            end
          end
          C_WAIT_REL: begin
            if (!coin_in) state_nx = C_IDLE;
          end
          default: begin
            state_nx = C_IDLE;
            cnt_nx   = '0;
          end
        endcase
      end
    end

    assign af_active = autofire_en[p] & btn_raw[0];

    // Autofire phase: starts high on press, toggles every AF_FRAMES ticks while held.
    always_ff @(posedge clk_sys) begin
      if (reset || lock || !af_active) begin
        af_phase <= 1'b1;
        af_cnt   <= AF_LOAD;
      end else if (tick) begin
        if (af_cnt <= 4'd1) begin
          af_phase <= ~af_phase;
          af_cnt   <= AF_LOAD;
        end else begin
          af_cnt <= af_cnt - 4'd1;
        end
      end
    end

    // Button 0 is replaced by the autofire phase only while autofire is engaged.
    always_comb begin
      btn_o    = btn_raw;
      btn_o[0] = af_active ? af_phase : btn_raw[0];
    end

    assign out_nx = {(state == C_PULSE), start_in, btn_o, right_o, left_o, down_o, up_o};

    // Registered player bus, cleared while a download holds the lock.
    always_ff @(posedge clk_sys) begin
      if (reset || lock) out_q <= '0;
      else               out_q <= out_nx;
    end

    assign player_out[W*p +: W] = out_q;
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: directed scenarios plus a randomized run,
// each checked against a frame-level behavioural model of the mapper.

module tb_arcade_input_mapper;

  localparam int NP   = 2;
  localparam int NB   = 1;
  localparam int COIN = 3;
  localparam int AF   = 2;
  localparam int W    = NB + 6;
  localparam int FR   = 8;

  logic            clk_sys = 1'b0;
  logic            reset;
  logic            vblank;
  logic            lock;
  logic            merged;
  logic [NP-1:0]   autofire_en;
  logic [NP*16-1:0] joystick;
  logic [NP*W-1:0] player_out;

  int vectors    = 0;
  int miscompares = 0;

  arcade_input_mapper #(
    .NPLAYERS(NP), .NBUTTONS(NB), .COIN_FRAMES(COIN), .AF_FRAMES(AF), .SOCD(1)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .vblank(vblank), .lock(lock),
    .merged(merged), .autofire_en(autofire_en), .joystick(joystick),
    .player_out(player_out)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference model: pulse frames remaining, release-needed flag, ticks held.
  int          m_pulse  [NP];
  bit          m_need   [NP];
  bit          m_pcoin  [NP];
  int          m_held   [NP];
  bit          m_pvb;
  logic [NP*W-1:0] exp_out;

  always @(posedge clk_sys) begin : model
    logic [15:0] orw, w;
    logic [W-1:0] o;
    bit tk, r, l, d, u, b0, st, cn;
    if (reset) begin
      exp_out = '0;
      m_pvb   = 1'b0;
      for (int p = 0; p < NP; p++) begin
        m_pulse[p] = 0; m_need[p] = 0; m_pcoin[p] = 0; m_held[p] = 0;
      end
    end else begin
      tk  = vblank && !m_pvb;
      orw = '0;
      for (int p = 0; p < NP; p++) orw = orw | joystick[16*p +: 16];
      for (int p = 0; p < NP; p++) begin
        w  = merged ? orw : joystick[16*p +: 16];
        r  = w[0]; l = w[1]; d = w[2]; u = w[3];
        if (l && r) begin l = 0; r = 0; end
        if (u && d) begin u = 0; d = 0; end
        b0 = w[4];
        if (merged) st = (p == 0) ? orw[5] : (p == 1) ? orw[6] : 1'b0;
        else        st = w[5];
        cn = w[7];
        if (lock) begin
          o = '0;
          m_pulse[p] = 0;
          m_need[p]  = 1;
          m_held[p]  = 0;
        end else begin
          if (autofire_en[p] && b0) begin
            b0 = ((m_held[p] / AF) % 2) == 0;
            if (tk) m_held[p]++;
          end else begin
            m_held[p] = 0;
          end
          o = {m_pulse[p] > 0, st, b0, r, l, d, u};
          if (m_pulse[p] > 0) begin
            if (tk) begin
              m_pulse[p]--;
              if (m_pulse[p] == 0) m_need[p] = 1;
            end
          end else if (m_need[p]) begin
            if (!cn) m_need[p] = 0;
          end else if (cn && !m_pcoin[p]) begin
            m_pulse[p] = COIN;
          end
        end
        m_pcoin[p] = cn;
        exp_out[W*p +: W] = o;
      end
      m_pvb = vblank;
    end
  end

  task automatic test_reset();
    reset = 1; lock = 0; merged = 0; autofire_en = '1; vblank = 0;
    for (int c = 0; c < 4; c++) begin
      joystick = {$urandom, $urandom} & 32'h00FF_00FF;
      vblank   = c[0];
      @(negedge clk_sys);
      vectors++;
      if (player_out !== '0)
        begin miscompares++; $display("FAIL reset_out cycle %0d: got %h want 0", c, player_out); end
    end
    joystick = '0; vblank = 0; autofire_en = '0;
    reset = 0;
    @(negedge clk_sys);
    vectors++;
    if (player_out !== '0)
      begin miscompares++; $display("FAIL reset_release: got %h want 0", player_out); end
  endtask

  task automatic test_merged_routing();
    logic [15:0] stim [6];
    logic        mg   [6];
    logic [NP*W-1:0] want [6];
    stim[0] = 16'h0011; mg[0] = 1; want[0] = {7'h18, 7'h18};
    stim[1] = 16'h0040; mg[1] = 1; want[1] = {7'h20, 7'h00};
    stim[2] = 16'h0040; mg[2] = 0; want[2] = '0;
    stim[3] = 16'h0020; mg[3] = 1; want[3] = {7'h00, 7'h20};
    stim[4] = 16'h0020; mg[4] = 0; want[4] = {7'h00, 7'h20};
    stim[5] = 16'h0011; mg[5] = 0; want[5] = {7'h00, 7'h18};
    for (int i = 0; i < 6; i++) begin
      merged = mg[i];
      // entries 0 and 5 drive player 1 / player 0 respectively to exercise both pads
      if (i == 0)      joystick = {stim[i], 16'h0000};
      else             joystick = {16'h0000, stim[i]};
      @(negedge clk_sys);
      vectors++;
      if (player_out !== want[i])
        begin miscompares++; $display("FAIL routing %0d: got %h want %h", i, player_out, want[i]); end
      vectors++;
      if (player_out !== exp_out)
        begin miscompares++; $display("FAIL routing_model %0d: got %h want %h", i, player_out, exp_out); end
    end
  endtask

  task automatic test_socd();
    logic [NP*16-1:0] stim [5];
    logic [NP*W-1:0]  want [5];
    stim[0] = {16'h0000, 16'h000F}; want[0] = '0;
    stim[1] = {16'h0000, 16'h0009}; want[1] = {7'h00, 7'h09};
    stim[2] = {16'h0000, 16'h0003}; want[2] = '0;
    stim[3] = {16'h000C, 16'h0000}; want[3] = '0;
    stim[4] = {16'h0006, 16'h0000}; want[4] = {7'h06, 7'h00};
    merged = 0;
    for (int i = 0; i < 5; i++) begin
      joystick = stim[i];
      @(negedge clk_sys);
      vectors++;
      if (player_out !== want[i])
        begin miscompares++; $display("FAIL socd %0d: got %h want %h", i, player_out, want[i]); end
    end
    joystick = '0;
    @(negedge clk_sys);
  endtask

  task automatic test_coin();
    int high_cycles = 0;
    int pulses = 0;
    bit prev = 0;
    bit held;
    merged = 0;
    for (int c = 0; c < 160; c++) begin
      held = (c >= 1 && c < 81) || (c >= 97 && c < 137);
      joystick = {16'h0000, held ? 16'h0080 : 16'h0000};
      vblank   = (c % FR) == 0;
      @(negedge clk_sys);
      vectors++;
      if (player_out !== exp_out)
        begin miscompares++; $display("FAIL coin_model c=%0d: got %h want %h", c, player_out, exp_out); end
      if (player_out[6]) high_cycles++;
      if (player_out[6] && !prev) pulses++;
      prev = player_out[6];
    end
    vectors++;
    if (pulses != 2)
      begin miscompares++; $display("FAIL coin_pulse_count: got %0d want 2", pulses); end
    vectors++;
    if (high_cycles != 2 * ((COIN - 1) * FR + FR - 1))
      begin miscompares++; $display("FAIL coin_pulse_len: got %0d want %0d", high_cycles, 2 * ((COIN - 1) * FR + FR - 1)); end
  endtask

  task automatic test_autofire();
    logic [7:0] pat = 8'b0011_0011;
    merged = 0; autofire_en = 2'b01;
    for (int c = 0; c < 66; c++) begin
      joystick = (c >= 1) ? {16'h0010, 16'h0010} : '0;
      vblank   = (c % FR) == 0;
      @(negedge clk_sys);
      vectors++;
      if (player_out !== exp_out)
        begin miscompares++; $display("FAIL af_model c=%0d: got %h want %h", c, player_out, exp_out); end
      if (c % FR == 4) begin
        vectors++;
        if (player_out[4] !== pat[c / FR])
          begin miscompares++; $display("FAIL af_p0_frame %0d: got %b want %b", c / FR, player_out[4], pat[c / FR]); end
        vectors++;
        if (player_out[W + 4] !== 1'b1)
          begin miscompares++; $display("FAIL af_p1_raw frame %0d: got %b want 1", c / FR, player_out[W + 4]); end
      end
    end
    joystick = '0; autofire_en = '0; vblank = 0;
    @(negedge clk_sys);
  endtask

  task automatic test_lock();
    int high_after = 0;
    int high_repress = 0;
    bit held;
    merged = 0;
    for (int c = 0; c < 82; c++) begin
      held = (c >= 1 && c < 41) || (c >= 49);
      joystick = {16'h0000, held ? 16'h0080 : 16'h0000};
      vblank   = (c % FR) == 0;
      lock     = (c == 4);
      @(negedge clk_sys);
      vectors++;
      if (player_out !== exp_out)
        begin miscompares++; $display("FAIL lock_model c=%0d: got %h want %h", c, player_out, exp_out); end
      if (c == 3) begin
        vectors++;
        if (player_out[6] !== 1'b1)
          begin miscompares++; $display("FAIL lock_precoin: got %b want 1", player_out[6]); end
      end
      if (c == 4) begin
        vectors++;
        if (player_out !== '0)
          begin miscompares++; $display("FAIL lock_clear: got %h want 0", player_out); end
      end
      if (c >= 5 && c <= 48 && player_out[6]) high_after++;
      if (c >= 49 && player_out[6]) high_repress++;
    end
    lock = 0;
    vectors++;
    if (high_after != 0)
      begin miscompares++; $display("FAIL lock_no_retrigger: got %0d high cycles want 0", high_after); end
    vectors++;
    if (high_repress != (COIN - 1) * FR + FR - 1)
      begin miscompares++; $display("FAIL lock_repress_pulse: got %0d want %0d", high_repress, (COIN - 1) * FR + FR - 1); end
    joystick = '0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_reset_mid_pulse();
    merged = 0;
    for (int c = 0; c < 20; c++) begin
      joystick = (c >= 1 && c < 14) ? {16'h0008, 16'h0091} : '0;
      vblank   = (c % FR) == 0;
      reset    = (c == 5);
      @(negedge clk_sys);
      if (c == 4) begin
        vectors++;
        if (player_out[6] !== 1'b1)
          begin miscompares++; $display("FAIL rst_pulse_live: got %b want 1", player_out[6]); end
      end
      if (c == 5) begin
        vectors++;
        if (player_out !== '0)
          begin miscompares++; $display("FAIL rst_mid_pulse: got %h want 0", player_out); end
      end else begin
        vectors++;
        if (player_out !== exp_out)
          begin miscompares++; $display("FAIL rst_model c=%0d: got %h want %h", c, player_out, exp_out); end
      end
    end
    reset = 0;
  endtask

  task automatic test_random();
    int vb_cnt = 0;
    int vb_per = 6;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 5) == 0)
          joystick[16*p +: 16] = 16'($urandom) & ($urandom_range(0, 3) == 0 ? 16'hFFFF : 16'h00FF);
      end
      if ($urandom_range(0, 60) == 0) merged = ~merged;
      if ($urandom_range(0, 40) == 0) autofire_en = 2'($urandom);
      lock = ($urandom_range(0, 150) == 0);
      vb_cnt++;
      if (vb_cnt >= vb_per) begin
        vb_cnt = 0;
        vb_per = $urandom_range(4, 10);
      end
      vblank = (vb_cnt < 2);
      @(negedge clk_sys);
      vectors++;
      if (player_out !== exp_out)
        begin miscompares++; $display("FAIL random c=%0d: got %h want %h", c, player_out, exp_out); end
    end
    lock = 0;
  endtask

  initial begin
    reset = 1; vblank = 0; lock = 0; merged = 0; autofire_en = '0; joystick = '0;
    test_reset();
    test_merged_routing();
    test_socd();
    test_coin();
    test_autofire();
    test_lock();
    test_reset_mid_pulse();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
